imem_port_arbiter: RTL and testbench

Shares one instruction-memory port (the ROM valid/ready request and response channels) between the Fetch stage and a secondary load requester (LSU/debug loader). It grants one request per cycle, holds a stalled grant stable, and records the source of every accepted request in an in-order outstanding queue. Responses are steered back to the correct requester, and Fetch responses are silently discarded after a fetch flush. It sits between Fetch/LSU and `instr_rom`.

---
 rtl/dhrutv_arb_pkg.sv | 8 +
 rtl/arb_src_fifo.sv | 50 +++++
 rtl/imem_port_arbiter.sv | 92 +++++++++
 tb/tb_imem_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dhrutv_arb_pkg.sv
// dhrutv_arb_pkg: shared types for the instruction-memory port arbiter.
package dhrutv_arb_pkg;
  typedef enum logic {SRC_IF = 1'b0, SRC_LS = 1'b1} src_e;
  typedef struct packed {
    src_e src;
    logic discard;
  } entry_t;
endpackage

// File: rtl/arb_src_fifo.sv
// arb_src_fifo: in-order queue of accepted-request sources with bulk discard of Fetch entries.
module arb_src_fifo
  import dhrutv_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  entry_t i_entry,
  input  logic   i_pop,
  input  logic   i_flush_if,
  output logic   o_full,
  output logic   o_empty,
  output entry_t o_head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  // A flush also discards the head being read out in the same cycle
  always_comb begin
    o_head = r_mem[r_rp];
    o_head.discard = o_head.discard || (i_flush_if && o_head.src == SRC_IF);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '{default: entry_t'('0)};
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (i_flush_if && r_mem[k].src == SRC_IF) r_mem[k].discard <= 1'b1;
      if (w_push) r_mem[r_wp] <= i_entry;
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop) r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one ROM request/response port between Fetch and a load requester.
// Define DHRUTV_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IF.
module imem_port_arbiter
  import dhrutv_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_vld,
  output logic              o_if_rdy,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_data,
  output logic              o_if_data_vld,
  input  logic              i_if_data_rdy,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic              i_ls_vld,
  output logic              o_ls_rdy,
  output logic [DATA_W-1:0] o_ls_data,
  output logic              o_ls_data_vld,
  input  logic              i_ls_data_rdy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_vld,
  input  logic              i_mem_rdy,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_data_vld,
  output logic              o_mem_data_rdy
);
  logic w_full, w_empty, w_if_req, w_ls_req, w_lock_if, w_lock_ls, w_pri_ls;
  logic w_gnt_if, w_gnt_ls, w_acc, w_pop, w_dst_ls, w_fwd;
  entry_t w_head, w_push_entry;
  logic r_lock;
  src_e r_lock_src;
  logic [ADDR_W-1:0] r_lock_addr;
  assign w_if_req = i_if_vld && !i_if_flush && !w_full;
  assign w_ls_req = i_ls_vld && !w_full;
  // A flush drops a stalled Fetch grant so the LSU can take the port
  assign w_lock_if = r_lock && r_lock_src == SRC_IF && !i_if_flush;
  assign w_lock_ls = r_lock && r_lock_src == SRC_LS;
`ifdef DHRUTV_ARB_RR_EN
  src_e r_last;
  assign w_pri_ls = r_last == SRC_IF;
  always_ff @(posedge clk) begin
    if (!rst_n) r_last <= SRC_LS;
    else if (w_acc) r_last <= w_gnt_ls ? SRC_LS : SRC_IF;
  end
`else
  assign w_pri_ls = 1'b1;
`endif
  assign w_gnt_ls = w_ls_req && !w_lock_if && (w_lock_ls || !w_if_req || w_pri_ls);
  assign w_gnt_if = w_if_req && !w_lock_ls && !w_gnt_ls;
  assign o_mem_vld = w_gnt_if || w_gnt_ls;
  assign o_mem_addr = !o_mem_vld ? '0 : (w_lock_if || w_lock_ls) ? r_lock_addr :
                      w_gnt_ls ? i_ls_addr : i_if_addr;
  assign w_acc = o_mem_vld && i_mem_rdy;
  assign o_if_rdy = w_acc && w_gnt_if;
  assign o_ls_rdy = w_acc && w_gnt_ls;
  assign w_push_entry = '{src: w_gnt_ls ? SRC_LS : SRC_IF, discard: 1'b0};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_lock_src <= SRC_IF;
      r_lock_addr <= '0;
    end else begin
      r_lock <= o_mem_vld && !i_mem_rdy;
      r_lock_src <= w_gnt_ls ? SRC_LS : SRC_IF;
      r_lock_addr <= o_mem_addr;
    end
  end
  assign w_dst_ls = w_head.src == SRC_LS;
  assign o_mem_data_rdy = !w_empty && (w_head.discard || (w_dst_ls ? i_ls_data_rdy : i_if_data_rdy));
  assign w_fwd = !w_empty && !w_head.discard && i_mem_data_vld;
  assign o_if_data_vld = w_fwd && !w_dst_ls;
  assign o_ls_data_vld = w_fwd && w_dst_ls;
  assign o_if_data = o_if_data_vld ? i_mem_data : '0;
  assign o_ls_data = o_ls_data_vld ? i_mem_data : '0;
  assign w_pop = i_mem_data_vld && o_mem_data_rdy;
  arb_src_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_acc),
    .i_entry   (w_push_entry),
    .i_pop     (w_pop),
    .i_flush_if(i_if_flush),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_imem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] i_if_addr = '0, i_ls_addr = '0, i_mem_data = '0;
  logic i_if_vld = 0, i_if_flush = 0, i_if_data_rdy = 0, i_ls_vld = 0, i_ls_data_rdy = 0;
  logic i_mem_rdy = 0, i_mem_data_vld = 0;
  logic [31:0] o_if_data, o_ls_data, o_mem_addr;
  logic o_if_rdy, o_if_data_vld, o_ls_rdy, o_ls_data_vld, o_mem_vld, o_mem_data_rdy;
  int vec = 0, errs = 0;
  logic [31:0] rom_q[$];
  logic rom_en = 0, rom_stale = 0;
  typedef struct {bit src; bit disc; logic [31:0] addr;} m_t;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_addr(i_if_addr), .i_if_vld(i_if_vld), .o_if_rdy(o_if_rdy), .i_if_flush(i_if_flush),
    .o_if_data(o_if_data), .o_if_data_vld(o_if_data_vld), .i_if_data_rdy(i_if_data_rdy),
    .i_ls_addr(i_ls_addr), .i_ls_vld(i_ls_vld), .o_ls_rdy(o_ls_rdy),
    .o_ls_data(o_ls_data), .o_ls_data_vld(o_ls_data_vld), .i_ls_data_rdy(i_ls_data_rdy),
    .o_mem_addr(o_mem_addr), .o_mem_vld(o_mem_vld), .i_mem_rdy(i_mem_rdy),
    .i_mem_data(i_mem_data), .i_mem_data_vld(i_mem_data_vld), .o_mem_data_rdy(o_mem_data_rdy)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  // ROM stand-in: answers accepted addresses in order, one cycle later at the earliest
  always @(negedge clk) begin
    if (!rst_n) rom_q.delete();
    else begin
      if (i_mem_data_vld && o_mem_data_rdy && rom_q.size() > 0) void'(rom_q.pop_front());
      if (o_mem_vld && i_mem_rdy) rom_q.push_back(o_mem_addr);
    end
  end
  always @(posedge clk) begin
    #2;
    i_mem_data_vld = rom_stale || (rom_en && rom_q.size() > 0);
    i_mem_data = rom_q.size() > 0 ? rom_f(rom_q[0]) : 32'hBAD0_BAD0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_if_vld = 0; i_ls_vld = 0; i_if_flush = 0;
    i_mem_rdy = 1; i_if_data_rdy = 1; i_ls_data_rdy = 1; rom_en = 1;
  endtask

  task automatic do_reset();
    cyc(); rst_n = 0; idle(); rom_stale = 0;
    cyc(); cyc(); rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vec++;
    if ({o_mem_vld, o_if_rdy, o_ls_rdy, o_mem_data_rdy, o_if_data_vld, o_ls_data_vld} !== 6'b0 ||
        o_mem_addr !== '0 || o_if_data !== '0 || o_ls_data !== '0) begin
      errs++;
      $display("FAIL reset_outputs: ctl=%b addr=%h required all zero",
               {o_mem_vld, o_if_rdy, o_ls_rdy, o_mem_data_rdy, o_if_data_vld, o_ls_data_vld}, o_mem_addr);
    end
  endtask

  task automatic test_if_stream();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc();
      i_if_vld = c < 3;
      i_if_addr = 32'(c * 4);
      @(negedge clk);
      if (c < 3) begin
        vec++;
        if (o_if_rdy !== 1'b1 || o_ls_rdy !== 1'b0 || o_mem_addr !== 32'(c * 4)) begin
          errs++;
          $display("FAIL if_stream_req%0d: if_rdy=%b ls_rdy=%b addr=%h required 1 0 %h",
                   c, o_if_rdy, o_ls_rdy, o_mem_addr, 32'(c * 4));
        end
      end
      if (c > 0) begin
        vec++;
        if (o_if_data_vld !== 1'b1 || o_if_data !== rom_f(32'((c - 1) * 4)) || o_ls_data_vld !== 1'b0) begin
          errs++;
          $display("FAIL if_stream_rsp%0d: if_v=%b data=%h ls_v=%b required 1 %h 0",
                   c, o_if_data_vld, o_if_data, o_ls_data_vld, rom_f(32'((c - 1) * 4)));
        end
      end
    end
    idle();
  endtask

  task automatic test_contention();
    logic exp_ls, prev_ls;
    prev_ls = 0;
    do_reset();
    cyc();
    i_if_vld = 1; i_ls_vld = 1; i_if_addr = 32'h100; i_ls_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
`ifdef DHRUTV_ARB_RR_EN
      exp_ls = (c == 1);
`else
      exp_ls = 1'b1;
`endif
      vec++;
      if (o_ls_rdy !== exp_ls || o_if_rdy !== !exp_ls || o_mem_addr !== (exp_ls ? i_ls_addr : i_if_addr)) begin
        errs++;
        $display("FAIL contention_gnt%0d: ls_rdy=%b if_rdy=%b addr=%h required ls_rdy=%b",
                 c, o_ls_rdy, o_if_rdy, o_mem_addr, exp_ls);
      end
      if (c > 0) begin
        vec++;
        if (o_ls_data_vld !== prev_ls || o_if_data_vld !== !prev_ls) begin
          errs++;
          $display("FAIL contention_rsp%0d: ls_v=%b if_v=%b required ls_v=%b", c, o_ls_data_vld, o_if_data_vld, prev_ls);
        end
      end
      prev_ls = exp_ls;
      cyc();
      if (exp_ls) i_ls_addr += 4;
      else i_if_addr += 4;
    end
    idle();
  endtask

  task automatic test_stall_lock();
    do_reset();
    cyc();
    rom_en = 0; i_mem_rdy = 0; i_if_vld = 1; i_if_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++;
      if (o_mem_vld !== 1'b1 || o_mem_addr !== 32'h10 || o_if_rdy !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold%0d: vld=%b addr=%h if_rdy=%b required 1 10 0", c, o_mem_vld, o_mem_addr, o_if_rdy);
      end
      cyc();
    end
    i_ls_vld = 1; i_ls_addr = 32'h20;
    @(negedge clk);
    vec++;
    if (o_mem_addr !== 32'h10 || o_ls_rdy !== 1'b0 || o_if_rdy !== 1'b0) begin
      errs++;
      $display("FAIL stall_ls_arrives: addr=%h ls_rdy=%b required 10 0", o_mem_addr, o_ls_rdy);
    end
    cyc(); i_mem_rdy = 1;
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b1 || o_ls_rdy !== 1'b0 || o_mem_addr !== 32'h10) begin
      errs++;
      $display("FAIL stall_release: if_rdy=%b ls_rdy=%b addr=%h required 1 0 10", o_if_rdy, o_ls_rdy, o_mem_addr);
    end
    cyc(); i_if_vld = 0;
    @(negedge clk);
    vec++;
    if (o_ls_rdy !== 1'b1 || o_mem_addr !== 32'h20) begin
      errs++;
      $display("FAIL stall_ls_next: ls_rdy=%b addr=%h required 1 20", o_ls_rdy, o_mem_addr);
    end
    cyc(); idle();
  endtask

  task automatic test_flush();
    do_reset();
    cyc();
    rom_en = 0; i_if_data_rdy = 0; i_if_vld = 1; i_if_addr = 32'h40;
    @(negedge clk);
    cyc(); i_if_addr = 32'h44;
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b1) begin
      errs++;
      $display("FAIL flush_setup: if_rdy=%b required 1", o_if_rdy);
    end
    cyc(); i_if_vld = 0; i_if_flush = 1;
    cyc(); i_if_flush = 0; rom_en = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec++;
      if (i_mem_data_vld !== 1'b1 || o_mem_data_rdy !== 1'b1 || o_if_data_vld !== 1'b0) begin
        errs++;
        $display("FAIL flush_discard%0d: mem_dv=%b data_rdy=%b if_v=%b required 1 1 0",
                 c, i_mem_data_vld, o_mem_data_rdy, o_if_data_vld);
      end
      cyc();
    end
    i_ls_vld = 1; i_ls_addr = 32'h80;
    @(negedge clk);
    vec++;
    if (o_ls_rdy !== 1'b1) begin
      errs++;
      $display("FAIL flush_ls_req: ls_rdy=%b required 1", o_ls_rdy);
    end
    cyc(); i_ls_vld = 0;
    @(negedge clk);
    vec++;
    if (o_ls_data_vld !== 1'b1 || o_ls_data !== rom_f(32'h80) || o_if_data_vld !== 1'b0) begin
      errs++;
      $display("FAIL flush_ls_rsp: ls_v=%b data=%h if_v=%b required 1 %h 0",
               o_ls_data_vld, o_ls_data, o_if_data_vld, rom_f(32'h80));
    end
    cyc();
    i_if_flush = 1; i_if_vld = 1; i_if_addr = 32'h50; i_ls_vld = 1; i_ls_addr = 32'h84;
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b0 || o_ls_rdy !== 1'b1 || o_mem_addr !== 32'h84) begin
      errs++;
      $display("FAIL flush_suppress: if_rdy=%b ls_rdy=%b addr=%h required 0 1 84", o_if_rdy, o_ls_rdy, o_mem_addr);
    end
    cyc(); i_if_flush = 0; i_ls_vld = 0; i_if_data_rdy = 1;
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b1 || o_mem_addr !== 32'h50 || o_ls_data_vld !== 1'b1) begin
      errs++;
      $display("FAIL flush_after: if_rdy=%b addr=%h ls_v=%b required 1 50 1", o_if_rdy, o_mem_addr, o_ls_data_vld);
    end
    cyc(); i_if_vld = 0;
    @(negedge clk);
    vec++;
    if (o_if_data_vld !== 1'b1 || o_if_data !== rom_f(32'h50)) begin
      errs++;
      $display("FAIL flush_if_rsp: if_v=%b data=%h required 1 %h", o_if_data_vld, o_if_data, rom_f(32'h50));
    end
    cyc(); i_mem_rdy = 0; i_if_vld = 1; i_if_addr = 32'h60;
    cyc(); i_if_flush = 1; i_ls_vld = 1; i_ls_addr = 32'h90; i_mem_rdy = 1;
    @(negedge clk);
    vec++;
    if (o_ls_rdy !== 1'b1 || o_if_rdy !== 1'b0 || o_mem_addr !== 32'h90) begin
      errs++;
      $display("FAIL flush_lock_release: ls_rdy=%b if_rdy=%b addr=%h required 1 0 90", o_ls_rdy, o_if_rdy, o_mem_addr);
    end
    cyc(); idle();
  endtask

  task automatic test_full();
    do_reset();
    cyc();
    rom_en = 0; i_if_vld = 1; i_if_addr = 32'h0;
    @(negedge clk);
    cyc(); i_if_addr = 32'h4;
    @(negedge clk);
    cyc(); i_if_addr = 32'h8;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vec++;
      if (o_mem_vld !== 1'b0 || o_if_rdy !== 1'b0) begin
        errs++;
        $display("FAIL full_block%0d: mem_vld=%b if_rdy=%b required 0 0", c, o_mem_vld, o_if_rdy);
      end
      cyc();
    end
    rom_en = 1;
    @(negedge clk);
    vec++;
    if (o_mem_vld !== 1'b0 || o_mem_data_rdy !== 1'b1 || o_if_data_vld !== 1'b1 || o_if_data !== rom_f(32'h0)) begin
      errs++;
      $display("FAIL full_pop_cycle: mem_vld=%b data_rdy=%b if_v=%b data=%h required 0 1 1 %h",
               o_mem_vld, o_mem_data_rdy, o_if_data_vld, o_if_data, rom_f(32'h0));
    end
    cyc();
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b1 || o_mem_addr !== 32'h8) begin
      errs++;
      $display("FAIL full_after_pop: if_rdy=%b addr=%h required 1 8", o_if_rdy, o_mem_addr);
    end
    cyc(); idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cyc();
    rom_en = 0; i_if_vld = 1; i_if_addr = 32'h30;
    cyc(); i_if_addr = 32'h34;
    cyc(); i_if_vld = 0; rst_n = 0;
    cyc(); rst_n = 1; rom_stale = 1;
    @(negedge clk);
    vec++;
    if (i_mem_data_vld !== 1'b1 || {o_mem_vld, o_if_rdy, o_ls_rdy, o_mem_data_rdy, o_if_data_vld, o_ls_data_vld} !== 6'b0 ||
        o_mem_addr !== '0) begin
      errs++;
      $display("FAIL reset_mid_outputs: ctl=%b addr=%h required all zero",
               {o_mem_vld, o_if_rdy, o_ls_rdy, o_mem_data_rdy, o_if_data_vld, o_ls_data_vld}, o_mem_addr);
    end
    cyc(); rom_stale = 0; i_if_vld = 1; i_if_addr = 32'h70;
    @(negedge clk);
    cyc(); i_if_addr = 32'h74;
    @(negedge clk);
    vec++;
    if (o_if_rdy !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_queue_empty: if_rdy=%b required 1", o_if_rdy);
    end
    cyc(); idle();
  endtask

  task automatic test_random();
    m_t mq[$];
    m_t h;
    int g, lock_src, last;
    bit lock, full, ifr, lsr, hd, if_acc, ls_acc;
    logic [5:0] e_ctl, a_ctl;
    logic [31:0] e_addr, e_data, a_data;
    logic e_drdy, e_ifv, e_lsv;
    lock = 0; lock_src = 0; last = 1; if_acc = 0; ls_acc = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!i_if_vld || if_acc || i_if_flush) begin
        i_if_vld = $urandom_range(0, 2) != 0;
        i_if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!i_ls_vld || ls_acc) begin
        i_ls_vld = $urandom_range(0, 2) == 0;
        i_ls_addr = 32'h8000 + (32'($urandom_range(0, 1023)) << 2);
      end
      i_if_flush = $urandom_range(0, 7) == 0;
      i_mem_rdy = $urandom_range(0, 3) != 0;
      i_if_data_rdy = $urandom_range(0, 3) != 0;
      i_ls_data_rdy = $urandom_range(0, 3) != 0;
      rom_en = $urandom_range(0, 3) != 0;
      @(negedge clk);
      full = mq.size() >= 2;
      ifr = i_if_vld && !i_if_flush && !full;
      lsr = i_ls_vld && !full;
      if (lock && !(lock_src == 0 && i_if_flush)) g = lock_src;
`ifdef DHRUTV_ARB_RR_EN
      else if (ifr && lsr) g = (last == 0) ? 1 : 0;
`else
      else if (ifr && lsr) g = 1;
`endif
      else g = lsr ? 1 : ifr ? 0 : -1;
      e_addr = g == 1 ? i_ls_addr : g == 0 ? i_if_addr : 32'h0;
      if_acc = g == 0 && i_mem_rdy;
      ls_acc = g == 1 && i_mem_rdy;
      e_drdy = 0; e_ifv = 0; e_lsv = 0; e_data = '0;
      if (mq.size() > 0) begin
        h = mq[0];
        hd = h.disc || (i_if_flush && !h.src);
        e_drdy = hd || (h.src ? i_ls_data_rdy : i_if_data_rdy);
        e_ifv = i_mem_data_vld && !hd && !h.src;
        e_lsv = i_mem_data_vld && !hd && h.src;
        e_data = rom_f(h.addr);
      end
      e_ctl = {g >= 0, if_acc, ls_acc, e_drdy, e_ifv, e_lsv};
      a_ctl = {o_mem_vld, o_if_rdy, o_ls_rdy, o_mem_data_rdy, o_if_data_vld, o_ls_data_vld};
      vec++;
      if (a_ctl !== e_ctl || o_mem_addr !== e_addr) begin
        errs++;
        $display("FAIL rand_ctl cyc=%0d: vld/ifr/lsr/drdy/ifv/lsv=%b addr=%h required %b addr=%h",
                 n, a_ctl, o_mem_addr, e_ctl, e_addr);
      end
      if (e_ifv || e_lsv) begin
        a_data = e_ifv ? o_if_data : o_ls_data;
        vec++;
        if (a_data !== e_data) begin
          errs++;
          $display("FAIL rand_data cyc=%0d: data=%h required %h", n, a_data, e_data);
        end
      end
      if (i_if_flush)
        foreach (mq[k]) if (!mq[k].src) mq[k].disc = 1;
      if (mq.size() > 0 && i_mem_data_vld && e_drdy) void'(mq.pop_front());
      if (if_acc || ls_acc) mq.push_back('{src: ls_acc, disc: 1'b0, addr: e_addr});
      lock = g >= 0 && !i_mem_rdy;
      lock_src = g;
      if (if_acc || ls_acc) last = g;
    end
    cyc(); idle();
  endtask

  initial begin
    test_reset();
    test_if_stream();
    test_contention();
    test_stall_lock();
    test_flush();
    test_full();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
